// File: rtl/ps2_command_tx.sv
// rtl/ps2_command_tx.sv - host-to-device PS/2 command byte transmitter
// Drives open-drain enables for PS2_CLK/PS2_DAT and clocks out one frame per request.
module ps2_command_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_TIMEOUT  = 750000,
  parameter int XFER_TIMEOUT   = 100000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] cmd_data,
  input  logic       send,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       clk_oe,
  output logic       dat_oe,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code
);

  localparam int MAX_A = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
  localparam int MAX_P = (MAX_A > XFER_TIMEOUT) ? MAX_A : XFER_TIMEOUT;
  localparam int CW    = $clog2(MAX_P + 1);

  // INHIBIT ends one cycle early so the REQ cycle completes the clock-low hold.
  localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYCLES - 2);
  localparam logic [CW-1:0] START_LAST = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] XFER_LAST  = CW'(XFER_TIMEOUT - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INHIBIT   = 3'd1;
  localparam logic [2:0] S_REQ       = 3'd2;
  localparam logic [2:0] S_WAIT_DEV  = 3'd3;
  localparam logic [2:0] S_SHIFT     = 3'd4;
  localparam logic [2:0] S_WAIT_ACK  = 3'd5;
  localparam logic [2:0] S_WAIT_IDLE = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    shift_q, shift_d;
  logic          clk_oe_q, clk_oe_d, dat_oe_q, dat_oe_d;
  logic          busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_prev_q, clk_prev_d;
  logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic          fall;
  logic [1:0]    abort_code;

  assign fall = clk_prev_q & ~clk_s2_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    clk_oe_d   = clk_oe_q;
    dat_oe_d   = dat_oe_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    err_code_d = err_code_q;
    abort_code = 2'b00;
    clk_s1_d   = ps2_clk_in;
    clk_s2_d   = clk_s1_q;
    clk_prev_d = clk_s2_q;
    dat_s1_d   = ps2_dat_in;
    dat_s2_d   = dat_s1_q;

    case (state_q)
      S_IDLE: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        if (send && !busy_q) begin
          shift_d    = {1'b1, ~^cmd_data, cmd_data};
          err_code_d = 2'b00;
          busy_d     = 1'b1;
          clk_oe_d   = 1'b1;
          cnt_d      = '0;
          state_d    = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == INH_LAST) begin
          dat_oe_d = 1'b1;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        clk_oe_d = 1'b0;
        cnt_d    = '0;
        state_d  = S_WAIT_DEV;
      end
      S_WAIT_DEV: begin
        if (fall) begin
          dat_oe_d  = ~shift_q[0];
          bit_cnt_d = 4'd1;
          cnt_d     = '0;
          state_d   = S_SHIFT;
        end else if (cnt_q == START_LAST) begin
          abort_code = 2'b01;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SHIFT: begin
        if (cnt_q == XFER_LAST) begin
          abort_code = 2'b10;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (fall) begin
            dat_oe_d  = ~shift_q[bit_cnt_q];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd9) state_d = S_WAIT_ACK;
          end
        end
      end
      S_WAIT_ACK: begin
        dat_oe_d = 1'b0;
        if (cnt_q == XFER_LAST) begin
          abort_code = 2'b10;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (fall) begin
            if (dat_s2_q) abort_code = 2'b11;
            else          state_d    = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (cnt_q == XFER_LAST) begin
          abort_code = 2'b10;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (clk_s2_q && dat_s2_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_code != 2'b00) begin
      clk_oe_d   = 1'b0;
      dat_oe_d   = 1'b0;
      error_d    = 1'b1;
      err_code_d = abort_code;
      busy_d     = 1'b0;
      state_d    = S_IDLE;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= 4'd0;
      shift_q    <= '0;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= 2'b00;
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      clk_oe_q   <= clk_oe_d;
      dat_oe_q   <= dat_oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
      clk_s1_q   <= clk_s1_d;
      clk_s2_q   <= clk_s2_d;
      clk_prev_q <= clk_prev_d;
      dat_s1_q   <= dat_s1_d;
      dat_s2_q   <= dat_s2_d;
    end
  end

  assign clk_oe   = clk_oe_q;
  assign dat_oe   = dat_oe_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_ps2_command_tx.sv
// tb/tb_ps2_command_tx.sv - bench for ps2_command_tx with a PS/2 device model
// Open-drain bus is modelled as a wired-AND of the host enables and the device drivers.
module tb_ps2_command_tx;

  localparam int INH   = 5000;
  localparam int START = 3000;
  localparam int XFER  = 1500;

  logic       CLOCK_50 = 1'b0;
  logic       reset, send;
  logic [7:0] cmd_data;
  logic       dev_clk = 1'b1, dev_dat = 1'b1;
  logic       ps2_clk_in, ps2_dat_in;
  logic       clk_oe, dat_oe, busy, done, error;
  logic [1:0] err_code;

  int vectors = 0, miscompares = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, cyc = 0, first_fall_cyc = 0;

  assign ps2_clk_in = dev_clk & ~clk_oe;
  assign ps2_dat_in = dev_dat & ~dat_oe;

  ps2_command_tx #(.INHIBIT_CYCLES(INH), .START_TIMEOUT(START), .XFER_TIMEOUT(XFER)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .cmd_data(cmd_data), .send(send),
    .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in), .clk_oe(clk_oe), .dat_oe(dat_oe),
    .busy(busy), .done(done), .error(error), .err_code(err_code)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  always @(negedge CLOCK_50) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (error === 1'b1) err_cnt <= err_cnt + 1;
    if (done === 1'b1 && error === 1'b1) both_cnt <= both_cnt + 1;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: start 0, data LSB first, odd parity, stop 1 (index 0 = start bit).
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += (b >> i) & 1;
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b, 1'b0};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    cmd_data = b;
    send = 1'b1;
    tick(1);
    send = 1'b0;
  endtask

  task automatic wait_release(output int hi, output int dat_idx);
    hi = 0;
    dat_idx = -1;
    while (clk_oe === 1'b1 && hi < 20000) begin
      if (dat_oe === 1'b1 && dat_idx < 0) dat_idx = hi;
      hi++;
      tick(1);
    end
  endtask

  task automatic device(input int h, input int nfalls, input bit ack_low, output logic [10:0] seen);
    seen = '0;
    tick(h);
    seen[0] = ps2_dat_in;
    for (int k = 1; k <= nfalls; k++) begin
      dev_clk = 1'b0;
      if (k == 1) first_fall_cyc = cyc;
      tick(h);
      if (k <= 10) seen[k] = ps2_dat_in;
      dev_clk = 1'b1;
      if (k == 10 && ack_low) dev_dat = 1'b0;
      tick(h);
    end
    dev_dat = 1'b1;
  endtask

  task automatic full_xfer(input string tag, input logic [7:0] b, input int h, input bit ack_low,
                           input logic [1:0] exp_code, output logic [10:0] seen);
    int hi, di, d0, e0, n;
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(b);
    check({tag, ".busy_on_accept"}, busy, 1);
    wait_release(hi, di);
    check({tag, ".inhibit_len"}, hi, INH);
    check({tag, ".dat_before_clk"}, di, INH - 1);
    device(h, 11, ack_low, seen);
    check({tag, ".frame"}, seen, frame_of(b));
    n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 500) begin
      tick(1);
      n++;
    end
    check({tag, ".done_pulses"}, done_cnt - d0, ack_low ? 1 : 0);
    check({tag, ".error_pulses"}, err_cnt - e0, ack_low ? 0 : 1);
    check({tag, ".err_code"}, err_code, exp_code);
    check({tag, ".idle_outputs"}, {busy, clk_oe, dat_oe}, 3'b000);
  endtask

  initial begin
    logic [10:0] seen;
    logic [7:0]  b;
    int hi, di, d0, e0, n, any_hi;

    reset = 1'b1;
    send = 1'b0;
    cmd_data = 8'h00;
    tick(3);
    check("reset.outputs", {clk_oe, dat_oe, busy, done, error, err_code}, 7'b0);
    reset = 1'b0;
    tick(2);
    check("post_reset.outputs", {clk_oe, dat_oe, busy, done, error, err_code}, 7'b0);

    full_xfer("ed", 8'hED, 20, 1'b1, 2'b00, seen);
    check("ed.data_bits", seen[8:1], 8'b1110_1101);
    check("ed.parity_stop", seen[10:9], 2'b11);

    full_xfer("zero", 8'h00, 15, 1'b1, 2'b00, seen);
    check("zero.parity", seen[9], 1'b1);
    full_xfer("one", 8'h01, 15, 1'b1, 2'b00, seen);
    check("one.parity", seen[9], 1'b0);

    for (int r = 0; r < 3; r++) begin
      full_xfer("rand", 8'($urandom), $urandom_range(30, 10), 1'b1, 2'b00, seen);
    end

    full_xfer("no_ack", 8'($urandom), 12, 1'b0, 2'b11, seen);

    // Device stalls mid-frame; a second send during the transfer must be dropped.
    d0 = done_cnt;
    e0 = err_cnt;
    b = 8'($urandom);
    send_byte(b);
    tick(100);
    send_byte(8'h55);
    wait_release(hi, di);
    device(20, 4, 1'b0, seen);
    check("stall.partial_frame", seen[4:0], frame_of(b) & 11'h01F);
    n = 0;
    while (error !== 1'b1 && n < XFER + 200) begin
      tick(1);
      n++;
    end
    check("stall.timeout_window", (cyc - first_fall_cyc >= XFER) && (cyc - first_fall_cyc <= XFER + 5), 1);
    check("stall.err_code", err_code, 2'b10);
    check("stall.busy_low", busy, 0);
    any_hi = 0;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (clk_oe === 1'b1 || busy === 1'b1) any_hi = 1;
    end
    check("stall.send_not_queued", any_hi, 0);
    check("stall.no_done", done_cnt - d0, 0);
    check("stall.one_error", err_cnt - e0, 1);

    // Reset in the middle of the data phase.
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(8'($urandom));
    wait_release(hi, di);
    device(20, 4, 1'b0, seen);
    reset = 1'b1;
    tick(1);
    check("midreset.outputs", {clk_oe, dat_oe, busy}, 3'b000);
    reset = 1'b0;
    tick(50);
    check("midreset.no_pulses", {done_cnt - d0, err_cnt - e0}, 64'd0);
    check("midreset.err_code", err_code, 2'b00);

    // Device never clocks.
    send_byte(8'hFF);
    wait_release(hi, di);
    check("nostart.inhibit_len", hi, INH);
    n = 0;
    while (error !== 1'b1 && n < START + 100) begin
      tick(1);
      n++;
    end
    check("nostart.latency", n, START);
    check("nostart.err_code", err_code, 2'b01);
    check("nostart.released", {clk_oe, dat_oe, busy}, 3'b000);

    check("never_done_and_error", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
